// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    // Receiver FSM states; prefixed so they never collide with module parameters.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_e;

    // System clocks per oversampling tick, rounded to nearest, never below 1.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int d;
        d = (clk_hz + (baud * os) / 2) / (baud * os);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_cmd_rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered head word.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == LW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // A push into a full FIFO only lands if a pop frees the slot in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_rdata = r_dout;
    assign o_level = r_count;

    // Storage array, kept free of reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Pointers, occupancy and the registered head word (held when empty).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            // Incoming word becomes the head when nothing else will be left ahead of it.
            if (w_push && (o_empty || (w_pop && r_count == LW'(1))))
                r_dout <= i_wdata;
            else if (w_pop && r_count > LW'(1))
                r_dout <= r_mem[r_rd_ptr + 1'b1];
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Oversampling UART receiver with majority vote, optional parity and output FIFO.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 108000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rxd,
    output logic [DATA_BITS-1:0]       o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_frame_err,
    output logic                       o_parity_err,
    output logic                       o_overrun,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                       o_busy
);
    localparam int      DIV      = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int      DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int      T_W      = $clog2(OVERSAMPLE);
    localparam int      B_W      = $clog2(DATA_BITS);
    localparam parity_e PAR_MODE = parity_e'(PARITY);
    localparam logic [T_W-1:0] T_VOTE_A = T_W'(OVERSAMPLE / 2 - 1);
    localparam logic [T_W-1:0] T_VOTE_B = T_W'(OVERSAMPLE / 2);
    localparam logic [T_W-1:0] T_DECIDE = T_W'(OVERSAMPLE / 2 + 1);
    localparam logic [T_W-1:0] T_LAST   = T_W'(OVERSAMPLE - 1);

    logic                 r_sync1, r_sync2;
    logic [DIV_W-1:0]     r_div_cnt;
    rx_state_e            r_state;
    logic [T_W-1:0]       r_t;
    logic [1:0]           r_votes;
    logic [B_W-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic                 r_push;
    logic                 r_frame_err, r_parity_err, r_overrun;
    logic                 w_tick, w_start_edge, w_maj, w_par_exp;
    logic                 w_pop, w_full, w_empty;

    assign w_tick       = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_start_edge = (r_state == S_IDLE) && !r_sync2;
    assign w_maj        = (r_votes[0] & r_votes[1]) | (r_votes[0] & r_sync2) | (r_votes[1] & r_sync2);
    assign w_par_exp    = (PAR_MODE == PAR_ODD) ? ~(^r_shift) : (^r_shift);
    assign o_valid      = !w_empty;
    assign w_pop        = o_valid && i_ready;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_overrun    = r_overrun;

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Oversampling tick divider, re-phased on every start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_edge || w_tick) r_div_cnt <= '0;
        else                                 r_div_cnt <= r_div_cnt + 1'b1;
    end

    // Frame FSM: votes on three mid-bit samples, decides stop at mid-bit, registers pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_t          <= '0;
            r_votes      <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bad    <= 1'b0;
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_state   <= S_START;
                        r_t       <= '0;
                        r_par_bad <= 1'b0;
                    end
                end
                S_WAIT_HIGH: begin
                    if (r_sync2) r_state <= S_IDLE;
                end
                default: begin
                    if (w_tick) begin
                        r_t <= (r_t == T_LAST) ? '0 : r_t + 1'b1;
                        if (r_t == T_VOTE_A) r_votes[0] <= r_sync2;
                        if (r_t == T_VOTE_B) r_votes[1] <= r_sync2;
                        if (r_t == T_DECIDE) begin
                            case (r_state)
                                S_START:  if (w_maj) r_state <= S_IDLE;
                                S_DATA:   r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                                S_PARITY: r_par_bad <= w_maj ^ w_par_exp;
                                S_STOP: begin
                                    if (!w_maj) begin
                                        r_frame_err <= 1'b1;
                                        r_state     <= S_WAIT_HIGH;
                                    end else if (r_par_bad) begin
                                        r_parity_err <= 1'b1;
                                        r_state      <= S_IDLE;
                                    end else begin
                                        r_push  <= 1'b1;
                                        r_state <= S_IDLE;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        if (r_t == T_LAST) begin
                            case (r_state)
                                S_START: begin
                                    r_state   <= S_DATA;
                                    r_bit_cnt <= '0;
                                end
                                S_DATA: begin
                                    if (r_bit_cnt == B_W'(DATA_BITS - 1))
                                        r_state <= (PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
                                    else
                                        r_bit_cnt <= r_bit_cnt + 1'b1;
                                end
                                S_PARITY: r_state <= S_STOP;
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Overrun pulse lines up with the cycle the dropped push would have landed.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_overrun <= 1'b0;
        else       r_overrun <= r_push && w_full && !w_pop;
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_push),
        .i_wdata (r_shift),
        .i_pop   (w_pop),
        .o_rdata (o_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench: two receivers (no parity / even parity) against a frame-level model.
module tb_uart_cmd_rx;
    localparam int BT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd   [2];
    logic       ready [2];
    logic [7:0] data  [2];
    logic       valid [2], fe [2], pe [2], ov [2], busy [2];
    logic [3:0] level [2];

    always #5 clk = ~clk;

    uart_cmd_rx #(.CLK_HZ(1600000), .BAUD(100000), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY(0), .FIFO_DEPTH(8)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_rxd(rxd[0]), .o_data(data[0]), .o_valid(valid[0]),
        .i_ready(ready[0]), .o_frame_err(fe[0]), .o_parity_err(pe[0]), .o_overrun(ov[0]),
        .o_level(level[0]), .o_busy(busy[0]));

    uart_cmd_rx #(.CLK_HZ(1600000), .BAUD(100000), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY(1), .FIFO_DEPTH(8)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_rxd(rxd[1]), .o_data(data[1]), .o_valid(valid[1]),
        .i_ready(ready[1]), .o_frame_err(fe[1]), .o_parity_err(pe[1]), .o_overrun(ov[1]),
        .o_level(level[1]), .o_busy(busy[1]));

    // Frame outcomes scheduled at the edge they must become visible: 0 push, 1 parity, 2 frame.
    typedef struct {
        int         edge_n;
        int         d;
        int         kind;
        logic [7:0] w;
    } ev_t;
    ev_t evq[$];

    int         cyc = 0;
    int         n_checks = 0, n_errors = 0;
    int         m_cnt [2], m_head [2];
    logic [7:0] m_buf [2][8];
    logic [7:0] exp_data [2];
    logic       exp_fe [2], exp_pe [2], exp_ov [2];
    int         fe_cnt [2], pe_cnt [2], ov_cnt [2];
    bit         rand_rdy = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int pre [2];
        bit popn [2];
        for (int d = 0; d < 2; d++) begin
            exp_fe[d] = 1'b0; exp_pe[d] = 1'b0; exp_ov[d] = 1'b0;
        end
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_cnt[d] = 0; m_head[d] = 0; exp_data[d] = 8'h00;
            end
            evq.delete();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            pre[d]  = m_cnt[d];
            popn[d] = (m_cnt[d] > 0) && (ready[d] == 1'b1);
            if (popn[d]) begin
                m_head[d] = (m_head[d] + 1) % 8;
                m_cnt[d]--;
            end
        end
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].edge_n == cyc) begin
                int d;
                d = evq[i].d;
                case (evq[i].kind)
                    0: begin
                        if (pre[d] == 8 && !popn[d]) exp_ov[d] = 1'b1;
                        else begin
                            m_buf[d][(m_head[d] + m_cnt[d]) % 8] = evq[i].w;
                            m_cnt[d]++;
                        end
                    end
                    1: exp_pe[d] = 1'b1;
                    default: exp_fe[d] = 1'b1;
                endcase
                evq.delete(i);
            end
        end
        for (int d = 0; d < 2; d++)
            if (m_cnt[d] > 0) exp_data[d] = m_buf[d][m_head[d]];
    endtask

    // Model update and full output comparison, 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            model_step();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("level%0d", d), 32'(level[d]), 32'(m_cnt[d]));
                check($sformatf("valid%0d", d), 32'(valid[d]), 32'(m_cnt[d] > 0));
                check($sformatf("data%0d", d), 32'(data[d]), 32'(exp_data[d]));
                check($sformatf("frame_err%0d", d), 32'(fe[d]), 32'(exp_fe[d]));
                check($sformatf("parity_err%0d", d), 32'(pe[d]), 32'(exp_pe[d]));
                check($sformatf("overrun%0d", d), 32'(ov[d]), 32'(exp_ov[d]));
                if (fe[d] === 1'b1) fe_cnt[d]++;
                if (pe[d] === 1'b1) pe_cnt[d]++;
                if (ov[d] === 1'b1) ov_cnt[d]++;
            end
        end
    end

    // Random consumer back-pressure, only while enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) begin
                ready[0] = 1'($urandom_range(0, 1));
                ready[1] = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame on line d and schedules its expected outcome.
    task automatic send(input int d, input logic [7:0] b, input bit par, input bit flip,
                        input int stop_low, input int gap);
        logic bits[$];
        int   n0, sb, dec;
        logic pbit;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        pbit = (^b) ^ flip;
        if (par) bits.push_back(pbit);
        if (stop_low > 0) for (int i = 0; i < stop_low; i++) bits.push_back(1'b0);
        else bits.push_back(1'b1);
        @(negedge clk);
        n0  = cyc + 1;
        sb  = par ? 10 : 9;
        dec = n0 + 12 + BT * sb;
        if (stop_low > 0)              evq.push_back('{dec, d, 2, 8'h00});
        else if (par && pbit != (^b))  evq.push_back('{dec, d, 1, 8'h00});
        else                           evq.push_back('{dec + 1, d, 0, b});
        foreach (bits[i]) begin
            rxd[d] = bits[i];
            repeat (BT) @(negedge clk);
        end
        rxd[d] = 1'b1;
        idle(gap);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    initial begin
        int s_fe, s_pe, s_ov;
        rxd[0] = 1'b1; rxd[1] = 1'b1;
        ready[0] = 1'b0; ready[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            fe_cnt[d] = 0; pe_cnt[d] = 0; ov_cnt[d] = 0; m_cnt[d] = 0; m_head[d] = 0;
            exp_data[d] = 8'h00;
        end
        idle(4);
        rst = 1'b0;
        idle(4);
        check("rst_level", 32'(level[0]), 0);
        check("rst_valid", 32'(valid[0]), 0);
        check("rst_data", 32'(data[0]), 0);
        check("rst_busy", 32'(busy[0]), 0);

        // Plain frame, then a single pop.
        send(0, 8'hA5, 1'b0, 1'b0, 0, 10);
        check("a5_data", 32'(data[0]), 32'h A5);
        check("a5_level", 32'(level[0]), 1);
        check("a5_valid", 32'(valid[0]), 1);
        ready[0] = 1'b1;
        @(negedge clk);
        ready[0] = 1'b0;
        @(negedge clk);
        check("a5_pop_level", 32'(level[0]), 0);

        // Even parity: good then bad parity bit.
        send(1, 8'h07, 1'b1, 1'b0, 0, 10);
        check("par_ok_data", 32'(data[1]), 32'h07);
        check("par_ok_level", 32'(level[1]), 1);
        ready[1] = 1'b1;
        @(negedge clk);
        ready[1] = 1'b0;
        s_pe = pe_cnt[1];
        send(1, 8'h07, 1'b1, 1'b1, 0, 10);
        check("par_bad_pulses", 32'(pe_cnt[1] - s_pe), 1);
        check("par_bad_level", 32'(level[1]), 0);

        // Break: stop held low for 40 bit times.
        s_fe = fe_cnt[0];
        fork
            send(0, 8'h3C, 1'b0, 1'b0, 40, 8);
            begin
                idle(400);
                check("break_busy", 32'(busy[0]), 1);
            end
        join
        check("break_pulses", 32'(fe_cnt[0] - s_fe), 1);
        check("break_level", 32'(level[0]), 0);
        check("break_idle", 32'(busy[0]), 0);

        // Short low glitch on the idle line.
        s_fe = fe_cnt[0]; s_pe = pe_cnt[0];
        @(negedge clk);
        rxd[0] = 1'b0;
        idle(4);
        rxd[0] = 1'b1;
        idle(4);
        check("glitch_busy", 32'(busy[0]), 1);
        idle(20);
        check("glitch_idle", 32'(busy[0]), 0);
        check("glitch_level", 32'(level[0]), 0);
        check("glitch_errs", 32'((fe_cnt[0] - s_fe) + (pe_cnt[0] - s_pe)), 0);

        // Fill past capacity, then drain in order.
        s_ov = ov_cnt[0];
        for (int i = 0; i < 9; i++) send(0, 8'(i), 1'b0, 1'b0, 0, 3);
        idle(4);
        check("full_level", 32'(level[0]), 8);
        check("full_overrun", 32'(ov_cnt[0] - s_ov), 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("drain%0d", i), 32'(data[0]), 32'(i));
            ready[0] = 1'b1;
            @(negedge clk);
            ready[0] = 1'b0;
        end
        idle(2);
        check("drain_level", 32'(level[0]), 0);

        // Reset in the middle of data bit 4, then a clean frame.
        s_fe = fe_cnt[0]; s_pe = pe_cnt[0];
        fork
            send(0, 8'hFF, 1'b0, 1'b0, 0, 20);
            begin
                idle(86);
                do_reset(3);
            end
        join
        check("rst_mid_level", 32'(level[0]), 0);
        send(0, 8'h5A, 1'b0, 1'b0, 0, 10);
        check("rst_after_data", 32'(data[0]), 32'h5A);
        check("rst_after_level", 32'(level[0]), 1);
        check("rst_after_errs", 32'((fe_cnt[0] - s_fe) + (pe_cnt[0] - s_pe)), 0);

        // Randomized frames with random back-pressure and occasional faults.
        rand_rdy = 1'b1;
        for (int k = 0; k < 30; k++) begin
            int  d, sl;
            bit  flip;
            d    = $urandom_range(0, 1);
            flip = (d == 1) && ($urandom_range(0, 3) == 0);
            sl   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            send(d, 8'($urandom), (d == 1), flip, sl, $urandom_range(3, 12));
        end
        @(negedge clk);
        rand_rdy = 1'b0;
        @(negedge clk);
        ready[0] = 1'b1; ready[1] = 1'b1;
        idle(300);
        check("events_drained", 32'(evq.size()), 0);
        check("final_level0", 32'(level[0]), 0);
        check("final_level1", 32'(level[1]), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
